tank_move_probe: RTL and testbench

Tank movement arbiter that drives the map's wall-query read port. It is the initiator side of the map lookup. On a move request it checks the tank's bounds and computes a candidate position. It then issues one pixel query per cycle along the tank's leading edge and consumes the map's registered wall answer one cycle later. Finally it commits or rejects the move. One instance per tank sits between the input/AI controller and the map.

---
 rtl/tank_pkg.sv | 23 ++
 rtl/tank_edge_gen.sv | 34 +++
 rtl/tank_move_probe.sv | 160 ++++++++++++++++
 tb/tb_tank_move_probe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared tank/map types: direction and probe FSM encodings plus playfield size
// used by the map, the renderer and the movement probe.
package tank_pkg;

    localparam int MAP_W = 200;
    localparam int MAP_H = 144;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        PROBE = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/tank_edge_gen.sv
// Maps a candidate position, direction and edge index to the leading-edge pixel
// that must be free for the move to be legal.
module tank_edge_gen
    import tank_pkg::*;
#(
    parameter int TANK_SZ = 8
) (
    input  dir_e       dir,
    input  logic [7:0] cx,
    input  logic [7:0] cy,
    input  logic [7:0] idx,
    output logic [7:0] px,
    output logic [7:0] py
);

    always_comb begin
        px = cx;
        py = cy;
        case (dir)
            UP: px = cx + idx;
            DOWN: begin
                px = cx + idx;
                py = cy + 8'(TANK_SZ - 1);
            end
            LEFT: py = cy + idx;
            RIGHT: begin
                px = cx + 8'(TANK_SZ - 1);
                py = cy + idx;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tank_move_probe.sv
// Tank movement arbiter: bounds-checks a move, scans the leading edge against the
// map's registered wall port, then commits or rejects. Option: PROBE_EARLY_ABORT_EN.
module tank_move_probe
    import tank_pkg::*;
#(
    parameter int TANK_SZ = 8,
    parameter int STEP    = 1,
    parameter int MAP_W   = tank_pkg::MAP_W,
    parameter int MAP_H   = tank_pkg::MAP_H,
    parameter int INIT_X  = 10,
    parameter int INIT_Y  = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       move_req,
    input  logic [1:0] move_dir,
    output logic       busy,
    output logic       probe_valid,
    output logic [7:0] probe_x,
    output logic [7:0] probe_y,
    input  logic       probe_wall,
    output logic       done,
    output logic       move_ok,
    output logic [7:0] pos_x,
    output logic [7:0] pos_y
);

    state_e     state, state_nx;
    dir_e       dir_q;
    logic [7:0] cx_q, cy_q, cand_x, cand_y;
    logic [7:0] idx, idx_nx;
    logic       hit, hit_nx;
    logic       bounds_rej, load_probe;
    logic [8:0] far_x, far_y;
    logic [7:0] eg_cx, eg_cy, eg_idx, eg_px, eg_py;

    // 9-bit far-edge sums keep the bounds test free of 8-bit wrap
    always_comb begin
        far_x      = {1'b0, pos_x} + 9'(TANK_SZ - 1 + STEP);
        far_y      = {1'b0, pos_y} + 9'(TANK_SZ - 1 + STEP);
        cand_x     = pos_x;
        cand_y     = pos_y;
        bounds_rej = 1'b0;
        case (dir_q)
            UP: begin
                cand_y     = pos_y - 8'(STEP);
                bounds_rej = ({1'b0, pos_y} < 9'(STEP));
            end
            DOWN: begin
                cand_y     = pos_y + 8'(STEP);
                bounds_rej = (far_y >= 9'(MAP_H));
            end
            LEFT: begin
                cand_x     = pos_x - 8'(STEP);
                bounds_rej = ({1'b0, pos_x} < 9'(STEP));
            end
            RIGHT: begin
                cand_x     = pos_x + 8'(STEP);
                bounds_rej = (far_x >= 9'(MAP_W));
            end
            default: ;
        endcase
    end

    // Query 0 is generated from the live candidate in CALC so it is on the port one edge later
    assign eg_cx  = (state == CALC) ? cand_x : cx_q;
    assign eg_cy  = (state == CALC) ? cand_y : cy_q;
    assign eg_idx = (state == CALC) ? 8'd0 : idx + 8'd1;

    tank_edge_gen #(.TANK_SZ(TANK_SZ)) u_edge_gen (
        .dir (dir_q),
        .cx  (eg_cx),
        .cy  (eg_cy),
        .idx (eg_idx),
        .px  (eg_px),
        .py  (eg_py)
    );

    always_comb begin
        state_nx   = state;
        hit_nx     = hit;
        idx_nx     = idx;
        load_probe = 1'b0;
        case (state)
            IDLE: if (move_req) state_nx = CALC;
            CALC: begin
                if (bounds_rej) begin
                    // Rejects pass through DRAIN so their done lands on the same edge budget as a probe setup
                    hit_nx   = 1'b1;
                    state_nx = DRAIN;
                end else begin
                    hit_nx     = 1'b0;
                    idx_nx     = 8'd0;
                    load_probe = 1'b1;
                    state_nx   = PROBE;
                end
            end
            PROBE: begin
                if (idx != 8'd0) hit_nx = hit | probe_wall;
                if (idx == 8'(TANK_SZ - 1)) begin
                    state_nx = DRAIN;
                end else begin
                    idx_nx     = idx + 8'd1;
                    load_probe = 1'b1;
                end
`ifdef PROBE_EARLY_ABORT_EN
                if ((idx != 8'd0) && probe_wall) begin
                    state_nx   = DONE;
                    load_probe = 1'b0;
                end
`endif
            end
            DRAIN: begin
                hit_nx   = hit | probe_wall;
                state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            idx         <= 8'd0;
            hit         <= 1'b0;
            probe_valid <= 1'b0;
            probe_x     <= 8'd0;
            probe_y     <= 8'd0;
            pos_x       <= 8'(INIT_X);
            pos_y       <= 8'(INIT_Y);
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            hit         <= hit_nx;
            probe_valid <= load_probe;
            if (load_probe) begin
                probe_x <= eg_px;
                probe_y <= eg_py;
            end
            if ((state_nx == DONE) && !hit_nx) begin
                pos_x <= cx_q;
                pos_y <= cy_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state == IDLE) && move_req) dir_q <= dir_e'(move_dir);
        if (state == CALC) begin
            cx_q <= cand_x;
            cy_q <= cand_y;
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign move_ok = done && !hit;

endmodule

// File: tb/tb_tank_move_probe.sv
// Bench for tank_move_probe: directed scenarios plus a random walk over a random
// wall map, checked against a footprint-level reference model.
module tb_tank_move_probe;

    localparam int TS   = 8;
    localparam int STEP = 1;
    localparam int MW   = 200;
    localparam int MH   = 144;

    logic       clk = 1'b0;
    logic       rstn;
    logic       move_req;
    logic [1:0] move_dir;
    logic       busy, probe_valid, probe_wall, done, move_ok;
    logic [7:0] probe_x, probe_y, pos_x, pos_y;

    tank_move_probe dut (
        .clk         (clk),
        .rstn        (rstn),
        .move_req    (move_req),
        .move_dir    (move_dir),
        .busy        (busy),
        .probe_valid (probe_valid),
        .probe_x     (probe_x),
        .probe_y     (probe_y),
        .probe_wall  (probe_wall),
        .done        (done),
        .move_ok     (move_ok),
        .pos_x       (pos_x),
        .pos_y       (pos_y)
    );

    always #5 clk = ~clk;

    bit wall [0:MW-1][0:MH-1];

    // Map model: registered wall answer one cycle after the query address
    always @(posedge clk) begin
        if (probe_x < MW && probe_y < MH) probe_wall <= wall[probe_x][probe_y];
        else                              probe_wall <= 1'b1;
    end

    logic [15:0] pq[$];
    int          done_cnt;

    always @(negedge clk) begin
        if (probe_valid === 1'b1) pq.push_back({probe_x, probe_y});
        if (done === 1'b1) done_cnt++;
    end

    int checks = 0;
    int errors = 0;
    int cur_x, cur_y;
    int e_lat, e_ok, e_x, e_y, e_nq;
    int eqx[TS];
    int eqy[TS];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_rect(input int x0, input int y0, input int x1, input int y1, input bit v);
        for (int x = x0; x <= x1; x++)
            for (int y = y0; y <= y1; y++)
                if (x >= 0 && x < MW && y >= 0 && y < MH) wall[x][y] = v;
    endtask

    task automatic set_borders();
        set_rect(0, 0, MW - 1, 1, 1'b1);
        set_rect(0, MH - 2, MW - 1, MH - 1, 1'b1);
        set_rect(0, 0, 1, MH - 1, 1'b1);
        set_rect(MW - 2, 0, MW - 1, MH - 1, 1'b1);
    endtask

    // Reference: the new footprint must lie inside the map, and the strip of it not
    // covered by the old footprint must be wall-free.
    task automatic model(input int d);
        int cx, cy, first;
        bit rej;
        cx = cur_x;
        cy = cur_y;
        case (d)
            0: cy = cy - STEP;
            1: cy = cy + STEP;
            2: cx = cx - STEP;
            default: cx = cx + STEP;
        endcase
        rej   = (cx < 0) || (cy < 0) || (cx + TS > MW) || (cy + TS > MH);
        first = -1;
        for (int i = 0; i < TS; i++) begin
            case (d)
                0: begin eqx[i] = cx + i;      eqy[i] = cy;          end
                1: begin eqx[i] = cx + i;      eqy[i] = cy + TS - 1; end
                2: begin eqx[i] = cx;          eqy[i] = cy + i;      end
                default: begin eqx[i] = cx + TS - 1; eqy[i] = cy + i; end
            endcase
            if (!rej && first < 0 && wall[eqx[i]][eqy[i]]) first = i;
        end
        e_ok = (!rej && first < 0) ? 1 : 0;
        e_x  = e_ok ? cx : cur_x;
        e_y  = e_ok ? cy : cur_y;
        if (rej) begin
            e_lat = 2;
            e_nq  = 0;
        end else begin
            e_lat = TS + 2;
            e_nq  = TS;
`ifdef PROBE_EARLY_ABORT_EN
            if (first >= 0) begin
                e_lat = 3 + first;
                e_nq  = (first + 2 < TS) ? first + 2 : TS;
            end
`endif
        end
    endtask

    task automatic do_move(input int d);
        int lat, bad, n;
        logic [15:0] ev;
        model(d);
        @(negedge clk);
        move_req = 1'b1;
        move_dir = 2'(d);
        @(posedge clk);
        #1;
        move_req = 1'b0;
        pq.delete();
        done_cnt = 0;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, e_lat);
        chk("move_ok", int'(move_ok), e_ok);
        chk("pos_x", int'(pos_x), e_x);
        chk("pos_y", int'(pos_y), e_y);
        chk("busy_in_done", int'(busy), 1);
        chk("probe_count", pq.size(), e_nq);
        bad = 0;
        n = (pq.size() < e_nq) ? pq.size() : e_nq;
        for (int k = 0; k < n; k++) begin
            ev = {8'(eqx[k]), 8'(eqy[k])};
            if (pq[k] !== ev) bad++;
        end
        chk("probe_seq", bad, 0);
        @(posedge clk);
        #1;
        chk("done_after", int'(done), 0);
        chk("busy_after", int'(busy), 0);
        chk("done_pulses", done_cnt, 1);
        cur_x = e_x;
        cur_y = e_y;
    endtask

    task automatic walk(input int d, input int n);
        repeat (n) do_move(d);
    endtask

    initial begin
        int lat;
        rstn     = 1'b1;
        move_req = 1'b0;
        move_dir = 2'd0;
        done_cnt = 0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_pos_x", int'(pos_x), 10);
        chk("rst_pos_y", int'(pos_y), 10);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_move_ok", int'(move_ok), 0);
        chk("rst_probe_valid", int'(probe_valid), 0);
        chk("rst_probe_x", int'(probe_x), 0);
        chk("rst_probe_y", int'(probe_y), 0);
        repeat (3) @(negedge clk);
        rstn  = 1'b1;
        cur_x = 10;
        cur_y = 10;

        // Free move on an empty map
        do_move(0);
        chk("free_pos_y", int'(pos_y), 9);

        // Outer wall rows 0..1 block the move from (10,2)
        set_borders();
        walk(0, 7);
        do_move(0);
        chk("wall_reject_ok", int'(move_ok), 0);

        // Partial-edge hit: only the last pixel of the row meets the wall
        walk(1, 19);
        walk(3, 13);
        set_rect(30, 20, 50, 20, 1'b1);
        do_move(0);
        chk("partial_pos_y", int'(pos_y), 21);
        set_rect(30, 20, 50, 20, 1'b0);

        // Bounds rejects at the map edges
        set_rect(0, 0, MW - 1, MH - 1, 1'b0);
        walk(1, 29);
        walk(2, 23);
        do_move(2);
        chk("left_bound_x", int'(pos_x), 0);
        walk(3, 192);
        do_move(3);
        chk("right_bound_x", int'(pos_x), 192);

        // Busy: a second request mid-probe is dropped
        @(negedge clk);
        move_req = 1'b1;
        move_dir = 2'd2;
        @(posedge clk);
        #1;
        move_req = 1'b0;
        done_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        move_req = 1'b1;
        move_dir = 2'd3;
        @(negedge clk);
        move_req = 1'b0;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = k + 4;
                break;
            end
        end
        chk("busy_latency", lat, TS + 2);
        repeat (15) @(posedge clk);
        #1;
        chk("busy_done_pulses", done_cnt, 1);
        chk("busy_pos_x", int'(pos_x), 191);
        chk("busy_idle", int'(busy), 0);
        cur_x = 191;

        // Reset mid-probe
        @(negedge clk);
        move_req = 1'b1;
        move_dir = 2'd0;
        @(posedge clk);
        #1;
        move_req = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        done_cnt = 0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_probe_valid", int'(probe_valid), 0);
        chk("mid_rst_pos_x", int'(pos_x), 10);
        chk("mid_rst_pos_y", int'(pos_y), 10);
        chk("mid_rst_probe_x", int'(probe_x), 0);
        chk("mid_rst_probe_y", int'(probe_y), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("post_rst_done_pulses", done_cnt, 0);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_move_ok", int'(move_ok), 0);
        chk("post_rst_pos_x", int'(pos_x), 10);
        cur_x = 10;
        cur_y = 10;

        // Random walk over a random wall map
        set_borders();
        for (int r = 0; r < 8; r++) begin
            int x0, y0;
            x0 = int'($urandom_range(20, MW - 30));
            y0 = int'($urandom_range(2, MH - 25));
            set_rect(x0, y0, x0 + int'($urandom_range(1, 18)), y0 + int'($urandom_range(1, 18)), 1'b1);
        end
        for (int m = 0; m < 60; m++) do_move(int'($urandom_range(0, 3)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
